// File: rtl/pheap_level.sv
// pheap_level: one level (LEVEL >= 2) of a pipelined heap.
// Holds 2^(LEVEL-1) nodes. Each command from the upstream level takes two
// cycles: an IDLE cycle that latches the command (done=WAIT) and an EXEC
// cycle that reads the children from the next level, computes the new node
// value, and forwards work downstream.
// Entry layout, MSB first: {active, capacity[LEVELS-1:0], key[7:0], value[7:0]}.
// Ports:
//   clk, rst                    clock; asynchronous active-low reset
//   start, op, in, addr         command from upstream (op: 0=LEQ 1=DEQ 2=ENQ_DEQ)
//   raddrTop -> rTopL, rTopR    node pair read port for upstream, with write bypass
//   raddrBot <- rBotL, rBotR    children pair read from the next level
//   done, endPos, out           status (0=DONE 1=WAIT 2=NEXT_LEVEL), chosen child,
//                               and the kv pushed to the next level
module pheap_level #(
  parameter int unsigned LEVEL  = 2,
  parameter bit          LAST   = 1'b0,
  parameter int unsigned LEVELS = 3,
  localparam int unsigned KEY_W = 8,
  localparam int unsigned VAL_W = 8,
  localparam int unsigned KV_W  = KEY_W + VAL_W,
  localparam int unsigned CAP_W = LEVELS,
  localparam int unsigned ENT_W = 1 + CAP_W + KV_W,
  localparam int unsigned AW    = LEVEL - 1,
  localparam int unsigned PW    = (LEVEL > 2) ? LEVEL - 2 : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [KV_W-1:0]  in,
  input  logic [AW-1:0]    addr,
  input  logic [PW-1:0]    raddrTop,
  output logic [ENT_W-1:0] rTopL,
  output logic [ENT_W-1:0] rTopR,
  output logic [AW-1:0]    raddrBot,
  input  logic [ENT_W-1:0] rBotL,
  input  logic [ENT_W-1:0] rBotR,
  output logic [1:0]       done,
  output logic             endPos,
  output logic [KV_W-1:0]  out
);

  localparam int unsigned NODES    = 2 ** AW;
  localparam int unsigned CAP_INIT = (2 ** (LEVELS - LEVEL + 1)) - 1;

  localparam logic [1:0] OP_LEQ     = 2'd0;
  localparam logic [1:0] OP_DEQ     = 2'd1;
  localparam logic [1:0] OP_ENQ_DEQ = 2'd2;

  localparam logic [1:0] DONE       = 2'd0;
  localparam logic [1:0] WAIT       = 2'd1;
  localparam logic [1:0] NEXT_LEVEL = 2'd2;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_EXEC = 1'b1;

  localparam logic [KV_W-1:0]  KV_EMPTY = '0;
  localparam logic [ENT_W-1:0] RST_ENT  = {1'b0, CAP_W'(CAP_INIT), KV_EMPTY};

  // Entry field accessors
  function automatic logic ent_act(input logic [ENT_W-1:0] e);
    return e[ENT_W-1];
  endfunction

  function automatic logic [CAP_W-1:0] ent_cap(input logic [ENT_W-1:0] e);
    return e[KV_W +: CAP_W];
  endfunction

  function automatic logic [KV_W-1:0] ent_kv(input logic [ENT_W-1:0] e);
    return e[KV_W-1:0];
  endfunction

  function automatic logic [KEY_W-1:0] kv_key(input logic [KV_W-1:0] kv);
    return kv[KV_W-1 -: KEY_W];
  endfunction

  logic [0:0]       state_q, state_d;
  logic [1:0]       op_q;
  logic [KV_W-1:0]  in_q;
  logic [AW-1:0]    addr_q;
  logic [ENT_W-1:0] mem_q [NODES];

  logic             we_c;
  logic [ENT_W-1:0] wdata_c;
  logic [ENT_W-1:0] node_c;
  logic [ENT_W-1:0] bot_l_c, bot_r_c, child_c;
  logic             r_wins_c, any_child_c, in_ge_node_c, in_ge_child_c, cap_r_gt_c;
  logic [CAP_W-1:0] cap_dec_c, cap_inc_c;
  logic [AW-1:0]    top_idx_l_c, top_idx_r_c;

  // Read pair indices; at LEVEL 2 the cast drops raddrTop entirely
  assign top_idx_l_c = AW'({raddrTop, 1'b0});
  assign top_idx_r_c = AW'({raddrTop, 1'b1});

  // Upstream read port with same-cycle bypass of the node being written
  always_comb begin
    rTopL = mem_q[top_idx_l_c];
    rTopR = mem_q[top_idx_r_c];
    if (we_c && ((addr_q >> 1) == (top_idx_l_c >> 1))) begin
      if (addr_q[0]) rTopR = wdata_c;
      else           rTopL = wdata_c;
    end
  end

  // The last level has no children: treat them as inactive with capacity 0
  assign bot_l_c = LAST ? '0 : rBotL;
  assign bot_r_c = LAST ? '0 : rBotR;

  assign node_c = mem_q[addr_q];

  // Right child wins only when strictly greater; inactive loses to active
  assign r_wins_c    = ent_act(bot_r_c) &&
                       (!ent_act(bot_l_c) || (kv_key(ent_kv(bot_r_c)) > kv_key(ent_kv(bot_l_c))));
  assign child_c     = r_wins_c ? bot_r_c : bot_l_c;
  assign any_child_c = ent_act(bot_l_c) || ent_act(bot_r_c);

  // Incoming kv wins ties against stored or child keys
  assign in_ge_node_c  = !ent_act(node_c)  || (kv_key(in_q) >= kv_key(ent_kv(node_c)));
  assign in_ge_child_c = !ent_act(child_c) || (kv_key(in_q) >= kv_key(ent_kv(child_c)));

  assign cap_r_gt_c = ent_cap(bot_r_c) > ent_cap(bot_l_c);
  assign cap_dec_c  = (ent_cap(node_c) == '0) ? '0 : ent_cap(node_c) - CAP_W'(1);
  assign cap_inc_c  = ent_cap(node_c) + CAP_W'(1);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next state, outputs and write data
  always_comb begin
    state_d  = state_q;
    done     = DONE;
    endPos   = 1'b0;
    out      = KV_EMPTY;
    raddrBot = '0;
    we_c     = 1'b0;
    wdata_c  = node_c;
    case (state_q)
      S_IDLE: begin
        if (start && rst) begin
          done    = WAIT;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d  = S_IDLE;
        raddrBot = addr_q;
        we_c     = 1'b1;
        case (op_q)
          OP_LEQ: begin
            if (!ent_act(node_c)) begin
              wdata_c = {1'b1, ent_cap(node_c) - CAP_W'(1), in_q};
            end else begin
              wdata_c = {1'b1, cap_dec_c, in_ge_node_c ? in_q : ent_kv(node_c)};
              endPos  = cap_r_gt_c;
              if (!LAST) begin
                done = NEXT_LEVEL;
                out  = in_ge_node_c ? ent_kv(node_c) : in_q;
              end
            end
          end
          OP_DEQ: begin
            if (!any_child_c) begin
              wdata_c = {1'b0, cap_inc_c, KV_EMPTY};
            end else begin
              wdata_c = {1'b1, cap_inc_c, ent_kv(child_c)};
              endPos  = r_wins_c;
              done    = NEXT_LEVEL;
            end
          end
          OP_ENQ_DEQ: begin
            if (in_ge_child_c) begin
              wdata_c = {1'b1, ent_cap(node_c), in_q};
            end else begin
              wdata_c = {1'b1, ent_cap(node_c), ent_kv(child_c)};
              endPos  = r_wins_c;
              out     = in_q;
              done    = NEXT_LEVEL;
            end
          end
          default: we_c = 1'b0;
        endcase
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Command latch
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q   <= OP_LEQ;
      in_q   <= KV_EMPTY;
      addr_q <= '0;
    end else if ((state_q == S_IDLE) && start) begin
      op_q   <= op;
      in_q   <= in;
      addr_q <= addr;
    end
  end

  // Node storage; written only at the edge that ends EXEC
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NODES; i++) mem_q[i] <= RST_ENT;
    end else if (we_c) begin
      mem_q[addr_q] <= wdata_c;
    end
  end

endmodule

// File: tb/tb_pheap_level.sv
// Self-checking bench for pheap_level at LEVELS=3, LEVEL=2, LAST=0.
module tb_pheap_level;

  localparam logic [1:0] OP_LEQ = 2'd0, OP_DEQ = 2'd1, OP_ENQ_DEQ = 2'd2;
  localparam logic [1:0] D_DONE = 2'd0, D_WAIT = 2'd1, D_NEXT = 2'd2;

  logic        clk, rst, start;
  logic [1:0]  op;
  logic [15:0] in_kv, out_kv;
  logic [0:0]  addr, raddr_top, raddr_bot;
  logic [19:0] rtop_l, rtop_r, rbot_l, rbot_r;
  logic [1:0]  done;
  logic        end_pos;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [1:0]  op;
    logic [15:0] in;
    logic        addr;
    logic [19:0] botl;
    logic [19:0] botr;
    logic [1:0]  done;
    logic        endpos;
    logic [15:0] out;
    logic [19:0] node;
  } step_t;

  step_t exp_q[$];

  pheap_level #(.LEVEL(2), .LAST(1'b0), .LEVELS(3)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .in(in_kv), .addr(addr),
    .raddrTop(raddr_top), .rTopL(rtop_l), .rTopR(rtop_r), .raddrBot(raddr_bot),
    .rBotL(rbot_l), .rBotR(rbot_r), .done(done), .endPos(end_pos), .out(out_kv)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [15:0] kv(input logic [7:0] k, input logic [7:0] v);
    return {k, v};
  endfunction

  function automatic logic [19:0] ent(input logic a, input logic [2:0] cap, input logic [15:0] kvv);
    return {a, cap, kvv};
  endfunction

  function automatic step_t mk(input logic [1:0] o, input logic [15:0] i, input logic a,
                               input logic [19:0] bl, input logic [19:0] br,
                               input logic [1:0] d, input logic ep, input logic [15:0] ov,
                               input logic [19:0] n);
    step_t s;
    s.op = o; s.in = i; s.addr = a; s.botl = bl; s.botr = br;
    s.done = d; s.endpos = ep; s.out = ov; s.node = n;
    return s;
  endfunction

  localparam logic [19:0] RST_ENT = 20'h30000;

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // Drives one command; returns at the EXEC-cycle negedge with the IDLE-cycle done
  task automatic launch(input step_t s, output logic [1:0] idle_done);
    @(posedge clk); #1;
    start = 1'b1; op = s.op; in_kv = s.in; addr = s.addr; rbot_l = s.botl; rbot_r = s.botr;
    @(negedge clk);
    idle_done = done;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b1; op = OP_LEQ; in_kv = kv(8'h55, 8'h55); addr = 1'b1;
    rbot_l = '0; rbot_r = '0;
    repeat (2) @(negedge clk);
    checks++; if (done !== D_DONE) begin failures++; $display("FAIL reset done got=%0d exp=%0d", done, D_DONE); end
    checks++; if (end_pos !== 1'b0) begin failures++; $display("FAIL reset endPos got=%0b exp=0", end_pos); end
    checks++; if (out_kv !== 16'h0) begin failures++; $display("FAIL reset out got=%h exp=0000", out_kv); end
    checks++; if (raddr_bot !== 1'b0) begin failures++; $display("FAIL reset raddrBot got=%0b exp=0", raddr_bot); end
    start = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checks++; if (rtop_l !== RST_ENT) begin failures++; $display("FAIL reset node0 got=%h exp=%h", rtop_l, RST_ENT); end
    checks++; if (rtop_r !== RST_ENT) begin failures++; $display("FAIL reset node1 got=%h exp=%h", rtop_r, RST_ENT); end
  endtask

  task automatic test_leq();
    step_t steps[5];
    step_t e;
    logic [1:0] idle_done;
    logic [19:0] obs;
    apply_reset();
    steps[0] = mk(OP_LEQ, kv(5, 8'h50), 1'b1, '0, '0, D_DONE, 1'b0, '0, ent(1, 2, kv(5, 8'h50)));
    steps[1] = mk(OP_LEQ, kv(9, 8'h90), 1'b0, '0, '0, D_DONE, 1'b0, '0, ent(1, 2, kv(9, 8'h90)));
    steps[2] = mk(OP_LEQ, kv(12, 8'hC0), 1'b0, ent(1, 1, kv(1, 1)), ent(1, 1, kv(2, 2)),
                  D_NEXT, 1'b0, kv(9, 8'h90), ent(1, 1, kv(12, 8'hC0)));
    steps[3] = mk(OP_LEQ, kv(3, 8'h30), 1'b0, ent(0, 0, '0), ent(0, 1, '0),
                  D_NEXT, 1'b1, kv(3, 8'h30), ent(1, 0, kv(12, 8'hC0)));
    steps[4] = mk(OP_LEQ, kv(12, 8'h33), 1'b0, '0, '0,
                  D_NEXT, 1'b0, kv(12, 8'hC0), ent(1, 0, kv(12, 8'h33)));
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(steps[i]);
      launch(steps[i], idle_done);
      e = exp_q.pop_front();
      obs = e.addr ? rtop_r : rtop_l;
      checks++; if (idle_done !== D_WAIT) begin failures++; $display("FAIL leq[%0d] idle done got=%0d exp=%0d", i, idle_done, D_WAIT); end
      checks++; if (done !== e.done) begin failures++; $display("FAIL leq[%0d] exec done got=%0d exp=%0d", i, done, e.done); end
      checks++; if (raddr_bot !== e.addr) begin failures++; $display("FAIL leq[%0d] raddrBot got=%0b exp=%0b", i, raddr_bot, e.addr); end
      if (e.done == D_NEXT) begin
        checks++; if (end_pos !== e.endpos) begin failures++; $display("FAIL leq[%0d] endPos got=%0b exp=%0b", i, end_pos, e.endpos); end
        checks++; if (out_kv !== e.out) begin failures++; $display("FAIL leq[%0d] out got=%h exp=%h", i, out_kv, e.out); end
      end
      checks++; if (obs !== e.node) begin failures++; $display("FAIL leq[%0d] bypass got=%h exp=%h", i, obs, e.node); end
      @(posedge clk); #1;
      obs = e.addr ? rtop_r : rtop_l;
      checks++; if (obs !== e.node) begin failures++; $display("FAIL leq[%0d] node got=%h exp=%h", i, obs, e.node); end
    end
  endtask

  task automatic test_deq();
    step_t steps[5];
    step_t e;
    logic [1:0] idle_done;
    logic [19:0] obs;
    apply_reset();
    steps[0] = mk(OP_LEQ, kv(9, 8'h90), 1'b0, '0, '0, D_DONE, 1'b0, '0, ent(1, 2, kv(9, 8'h90)));
    steps[1] = mk(OP_DEQ, kv(1, 1), 1'b0, ent(1, 0, kv(9, 8'h99)), ent(0, 3, kv(20, 8'h20)),
                  D_NEXT, 1'b0, '0, ent(1, 3, kv(9, 8'h99)));
    steps[2] = mk(OP_DEQ, kv(1, 1), 1'b0, ent(1, 0, kv(4, 8'h44)), ent(1, 0, kv(7, 8'h77)),
                  D_NEXT, 1'b1, '0, ent(1, 4, kv(7, 8'h77)));
    steps[3] = mk(OP_DEQ, kv(1, 1), 1'b0, ent(1, 0, kv(6, 8'h61)), ent(1, 0, kv(6, 8'h62)),
                  D_NEXT, 1'b0, '0, ent(1, 5, kv(6, 8'h61)));
    steps[4] = mk(OP_DEQ, kv(1, 1), 1'b0, ent(0, 2, kv(8, 8)), ent(0, 2, kv(9, 9)),
                  D_DONE, 1'b0, '0, ent(0, 6, '0));
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(steps[i]);
      launch(steps[i], idle_done);
      e = exp_q.pop_front();
      obs = e.addr ? rtop_r : rtop_l;
      checks++; if (idle_done !== D_WAIT) begin failures++; $display("FAIL deq[%0d] idle done got=%0d exp=%0d", i, idle_done, D_WAIT); end
      checks++; if (done !== e.done) begin failures++; $display("FAIL deq[%0d] exec done got=%0d exp=%0d", i, done, e.done); end
      if (e.done == D_NEXT) begin
        checks++; if (end_pos !== e.endpos) begin failures++; $display("FAIL deq[%0d] endPos got=%0b exp=%0b", i, end_pos, e.endpos); end
      end
      if (e.op == OP_DEQ) begin
        checks++; if (out_kv !== 16'h0) begin failures++; $display("FAIL deq[%0d] out got=%h exp=0000", i, out_kv); end
      end
      checks++; if (obs !== e.node) begin failures++; $display("FAIL deq[%0d] bypass got=%h exp=%h", i, obs, e.node); end
      @(posedge clk); #1;
      obs = e.addr ? rtop_r : rtop_l;
      checks++; if (obs !== e.node) begin failures++; $display("FAIL deq[%0d] node got=%h exp=%h", i, obs, e.node); end
    end
  endtask

  task automatic test_enq_deq();
    step_t steps[5];
    step_t e;
    logic [1:0] idle_done;
    logic [19:0] obs;
    apply_reset();
    steps[0] = mk(OP_LEQ, kv(1, 8'h10), 1'b1, '0, '0, D_DONE, 1'b0, '0, ent(1, 2, kv(1, 8'h10)));
    steps[1] = mk(OP_ENQ_DEQ, kv(6, 8'h66), 1'b1, ent(1, 0, kv(3, 8'h33)), ent(1, 0, kv(6, 8'h6F)),
                  D_DONE, 1'b0, '0, ent(1, 2, kv(6, 8'h66)));
    steps[2] = mk(OP_ENQ_DEQ, kv(2, 8'h22), 1'b1, ent(1, 0, kv(3, 8'h33)), ent(1, 0, kv(6, 8'h6F)),
                  D_NEXT, 1'b1, kv(2, 8'h22), ent(1, 2, kv(6, 8'h6F)));
    steps[3] = mk(OP_ENQ_DEQ, kv(4, 8'h44), 1'b1, ent(1, 0, kv(5, 8'h51)), ent(1, 0, kv(5, 8'h52)),
                  D_NEXT, 1'b0, kv(4, 8'h44), ent(1, 2, kv(5, 8'h51)));
    steps[4] = mk(OP_ENQ_DEQ, kv(4, 8'h45), 1'b1, ent(0, 0, kv(9, 8'h90)), ent(1, 0, kv(7, 8'h70)),
                  D_NEXT, 1'b1, kv(4, 8'h45), ent(1, 2, kv(7, 8'h70)));
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(steps[i]);
      launch(steps[i], idle_done);
      e = exp_q.pop_front();
      obs = e.addr ? rtop_r : rtop_l;
      checks++; if (done !== e.done) begin failures++; $display("FAIL enqdeq[%0d] exec done got=%0d exp=%0d", i, done, e.done); end
      if (e.done == D_NEXT) begin
        checks++; if (end_pos !== e.endpos) begin failures++; $display("FAIL enqdeq[%0d] endPos got=%0b exp=%0b", i, end_pos, e.endpos); end
        checks++; if (out_kv !== e.out) begin failures++; $display("FAIL enqdeq[%0d] out got=%h exp=%h", i, out_kv, e.out); end
      end
      checks++; if (obs !== e.node) begin failures++; $display("FAIL enqdeq[%0d] bypass got=%h exp=%h", i, obs, e.node); end
      @(posedge clk); #1;
      obs = e.addr ? rtop_r : rtop_l;
      checks++; if (obs !== e.node) begin failures++; $display("FAIL enqdeq[%0d] node got=%h exp=%h", i, obs, e.node); end
      checks++; if (end_pos !== 1'b0 || out_kv !== 16'h0) begin failures++; $display("FAIL enqdeq[%0d] idle outputs got=%0b/%h exp=0/0000", i, end_pos, out_kv); end
    end
  endtask

  task automatic test_bypass();
    step_t s;
    logic [1:0] idle_done;
    apply_reset();
    s = mk(OP_LEQ, kv(5, 8'h50), 1'b1, '0, '0, D_DONE, 1'b0, '0, ent(1, 2, kv(5, 8'h50)));
    launch(s, idle_done);
    @(posedge clk); #1;
    s = mk(OP_LEQ, kv(8, 8'h88), 1'b1, '0, '0, D_NEXT, 1'b0, kv(5, 8'h50), ent(1, 1, kv(8, 8'h88)));
    exp_q.push_back(s);
    launch(s, idle_done);
    s = exp_q.pop_front();
    checks++; if (rtop_r !== s.node) begin failures++; $display("FAIL bypass rTopR got=%h exp=%h", rtop_r, s.node); end
    checks++; if (rtop_l !== RST_ENT) begin failures++; $display("FAIL bypass rTopL got=%h exp=%h", rtop_l, RST_ENT); end
    checks++; if (out_kv !== s.out) begin failures++; $display("FAIL bypass out got=%h exp=%h", out_kv, s.out); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_exec();
    step_t s;
    logic [1:0] idle_done;
    apply_reset();
    s = mk(OP_LEQ, kv(9, 8'h90), 1'b1, '0, '0, D_DONE, 1'b0, '0, ent(1, 2, kv(9, 8'h90)));
    launch(s, idle_done);
    rst = 1'b0;
    #1;
    checks++; if (done !== D_DONE) begin failures++; $display("FAIL midreset done got=%0d exp=%0d", done, D_DONE); end
    checks++; if (raddr_bot !== 1'b0) begin failures++; $display("FAIL midreset raddrBot got=%0b exp=0", raddr_bot); end
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (rtop_l !== RST_ENT) begin failures++; $display("FAIL midreset node0 got=%h exp=%h", rtop_l, RST_ENT); end
    checks++; if (rtop_r !== RST_ENT) begin failures++; $display("FAIL midreset node1 got=%h exp=%h", rtop_r, RST_ENT); end
  endtask

  // start held high across EXEC: the EXEC-cycle command must be ignored
  task automatic test_back_to_back();
    apply_reset();
    rbot_l = '0; rbot_r = '0;
    @(posedge clk); #1;
    start = 1'b1; op = OP_LEQ; addr = 1'b1; in_kv = kv(10, 8'hA0);
    @(negedge clk);
    checks++; if (done !== D_WAIT) begin failures++; $display("FAIL b2b c0 done got=%0d exp=%0d", done, D_WAIT); end
    @(posedge clk); #1;
    in_kv = kv(11, 8'hB0);
    @(negedge clk);
    checks++; if (done !== D_DONE) begin failures++; $display("FAIL b2b c1 done got=%0d exp=%0d", done, D_DONE); end
    checks++; if (raddr_bot !== 1'b1) begin failures++; $display("FAIL b2b c1 raddrBot got=%0b exp=1", raddr_bot); end
    @(posedge clk); #1;
    in_kv = kv(12, 8'hC0);
    @(negedge clk);
    checks++; if (done !== D_WAIT) begin failures++; $display("FAIL b2b c2 done got=%0d exp=%0d", done, D_WAIT); end
    checks++; if (rtop_r !== ent(1, 2, kv(10, 8'hA0))) begin failures++; $display("FAIL b2b c2 node1 got=%h exp=%h", rtop_r, ent(1, 2, kv(10, 8'hA0))); end
    @(posedge clk); #1;
    in_kv = kv(13, 8'hD0);
    @(negedge clk);
    checks++; if (done !== D_NEXT) begin failures++; $display("FAIL b2b c3 done got=%0d exp=%0d", done, D_NEXT); end
    checks++; if (out_kv !== kv(10, 8'hA0)) begin failures++; $display("FAIL b2b c3 out got=%h exp=%h", out_kv, kv(10, 8'hA0)); end
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    checks++; if (rtop_r !== ent(1, 1, kv(12, 8'hC0))) begin failures++; $display("FAIL b2b final node1 got=%h exp=%h", rtop_r, ent(1, 1, kv(12, 8'hC0))); end
    checks++; if (done !== D_DONE) begin failures++; $display("FAIL b2b final done got=%0d exp=%0d", done, D_DONE); end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; op = OP_LEQ; in_kv = '0; addr = '0;
    raddr_top = '0; rbot_l = '0; rbot_r = '0;
    test_reset();
    test_leq();
    test_deq();
    test_enq_deq();
    test_bypass();
    test_reset_mid_exec();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
